// File: rtl/uart_dec_parser.sv
// uart_dec_parser: assembles ASCII decimal numbers from the UART byte stream.
// A number is a run of digit bytes closed by CR or LF. A good number updates
// `value` and pulses `value_valid`. Malformed input, line errors and
// out-of-range numbers raise one-cycle error strobes, then the rest of the
// line is dropped up to the next terminator.
module uart_dec_parser #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data,
  input  logic             data_ready,
  input  logic             comm_err,
  output logic [WIDTH-1:0] value,
  output logic             value_valid,
  output logic             parse_err,
  output logic             overflow,
  output logic             busy
);

  // Four spare bits let acc*10+9 of the largest legal value fit without wrap.
  localparam int AW = WIDTH + 4;
  // The count must be able to reach MAX_DIGITS+1 so an extra digit is visible.
  localparam int CW = $clog2(MAX_DIGITS + 2);
  localparam logic [AW-1:0] MAX_VAL = {{4{1'b0}}, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DISCARD} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   acc, acc_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0] value_nxt;
  logic            vv_nxt, pe_nxt, ov_nxt;

  logic            is_digit, is_term;
  logic [AW-1:0]   d_ext, acc_step;
  logic [CW-1:0]   cnt_inc;

  // Byte classification and the digit-append arithmetic.
  always_comb begin
    is_digit = (data >= 8'h30) && (data <= 8'h39);
    is_term  = (data == 8'h0D) || (data == 8'h0A);
    // For 0x30..0x39 the low nibble is already the digit value.
    d_ext    = {{(AW-4){1'b0}}, data[3:0]};
    acc_step = (acc << 3) + (acc << 1) + d_ext;
    cnt_inc  = cnt + CW'(1);
  end

  // Next-state, datapath and strobe decisions; comm_err overrides any byte.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    value_nxt = value;
    vv_nxt    = 1'b0;
    pe_nxt    = 1'b0;
    ov_nxt    = 1'b0;
    if (comm_err) begin
      // Only the first cycle of an episode reports; DISCARD stays silent.
      pe_nxt    = (state != S_DISCARD);
      state_nxt = S_DISCARD;
      acc_nxt   = '0;
      cnt_nxt   = '0;
    end else if (data_ready) begin
      unique case (state)
        S_IDLE: begin
          if (is_digit) begin
            acc_nxt   = d_ext;
            cnt_nxt   = CW'(1);
            state_nxt = S_ACCUM;
          end else if (!is_term) begin
            // Bare terminators (CRLF, blank lines) are silently ignored.
            pe_nxt    = 1'b1;
            state_nxt = S_DISCARD;
          end
        end
        S_ACCUM: begin
          if (is_digit) begin
            if ((acc_step > MAX_VAL) || (cnt_inc > CW'(MAX_DIGITS))) begin
              ov_nxt    = 1'b1;
              state_nxt = S_DISCARD;
              acc_nxt   = '0;
              cnt_nxt   = '0;
            end else begin
              acc_nxt = acc_step;
              cnt_nxt = cnt_inc;
            end
          end else if (is_term) begin
            value_nxt = acc[WIDTH-1:0];
            vv_nxt    = 1'b1;
            state_nxt = S_IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
          end else begin
            pe_nxt    = 1'b1;
            state_nxt = S_DISCARD;
            acc_nxt   = '0;
            cnt_nxt   = '0;
          end
        end
        S_DISCARD: begin
          if (is_term) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      acc         <= '0;
      cnt         <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      parse_err   <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      cnt         <= cnt_nxt;
      value       <= value_nxt;
      value_valid <= vv_nxt;
      parse_err   <= pe_nxt;
      overflow    <= ov_nxt;
      busy        <= (state_nxt != S_IDLE);
    end
  end

endmodule
